pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
- Single-channel PWM generator with a controller front end. Software-side logic loads period, target duty and ramp step over a valid/ready handshake.
- Loaded values are shadowed and applied only at a period boundary, so no glitched pulse is ever produced.
- Duty slews toward the target in fixed steps every RAMP_DIV periods (soft start and soft change).
- Sits between the control/config logic and the power-stage or LED drive pin.

Parameters:
- CNT_W, 16, width of the period counter, period and duty values
- STEP_W, 8, width of the ramp step
- RAMP_DIV, 4, number of completed periods between ramp steps (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run request; low = output stopped
- cfg_valid  in  1  config word offered
- cfg_ready  out  1  config slot free
- cfg_period  in  CNT_W  period in clocks
- cfg_duty  in  CNT_W  target high time in clocks
- cfg_step  in  STEP_W  ramp increment per step; 0 = jump
- pwm  out  1  PWM output (registered)
- period_end  out  1  one-cycle pulse on the last cycle of each period
- cur_duty  out  CNT_W  duty currently applied
- busy  out  1  ramp in progress (cur_duty != target)

Behaviour:
- Reset (async, active-high) sets: cnt=0, period_reg=1, target=0, step_reg=0, cur_duty=0, pending=0, ramp_div_cnt=0, pwm=0, period_end=0, cfg_ready=1, busy=0, state=IDLE.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready. Inputs are captured into shadow registers and pending=1.
  - cfg_ready = !pending.
  - While cfg_valid is high without a transfer, the inputs are ignored and do not need to be held stable.
- Shadow apply:
  - In RUN/RAMP, pending values are copied into period_reg/target/step_reg on the cycle period_end is high. pending clears and cfg_ready rises the following cycle.
  - In IDLE, they are applied the cycle after the transfer.
- Clamping at apply:
  - A period of 0 is stored as 1.
  - A duty greater than the period is stored as period_reg (100%).
- Counter:
  - When enabled, cnt counts 0..period_reg-1 and then wraps to 0.
  - period_end is registered and high during the cycle cnt==period_reg-1.
  - pwm is registered: pwm(t+1) = enable && (cnt(t) < cur_duty(t)).
- Ramp:
  - ramp_div_cnt increments on each period_end while cur_duty != target.
  - When it reaches RAMP_DIV-1 on a period_end, it clears and cur_duty moves toward target by step_reg, saturating at target (never overshoots).
  - If step_reg == 0, cur_duty is set to target at the next period_end.
  - cur_duty changes only on a period_end cycle.
  - A new target arriving mid-ramp is adopted at the period_end where it is applied. Ramping continues from the present cur_duty and ramp_div_cnt is not cleared.
- FSM:
  - IDLE: enable=0. cnt held at 0, pwm=0, period_end=0. → RUN when enable=1.
  - RUN: cur_duty == target, busy=0. → RAMP when target != cur_duty after an apply. → IDLE when enable=0.
  - RAMP: busy=1. → RUN on the step that reaches target. → IDLE when enable=0.
- Enable drop:
  - Next cycle: cnt=0, pwm=0, ramp_div_cnt=0.
  - cur_duty and target are retained.
  - Ramping resumes from the retained cur_duty when re-enabled.
- Edge cases:
  - Duty 0 gives pwm constantly low.
  - Duty == period gives pwm constantly high while enabled.
  - Period 1: period_end is high every cycle.

Optional Feature:
- Macro: PWM_SOFT_STOP_EN.
- When defined: deasserting enable does not stop immediately.
  - Add state STOPPING, in which target is forced to 0 and ramping continues at step_reg/RAMP_DIV.
  - Once cur_duty == 0 at a period_end, → IDLE.
  - busy stays 1 while in STOPPING.
  - Reasserting enable in STOPPING → RAMP toward the stored target.
  - cfg transfers are still accepted in STOPPING; they apply at period_end, but the target forcing continues.
- When not defined: enable low → IDLE as described in Behaviour; state STOPPING does not exist.

Test Plan:
- Reset then enable=1 with no config: period_reg=1, cur_duty=0 → pwm stays 0, period_end high every cycle.
- Config period=10, duty=3, step=0, then enable: after the first period_end, pwm high for 3 clocks and low for 7, repeating. period_end is high on the cycle cnt==9.
- Config period=20, duty=12, step=4, RAMP_DIV=2, from cur_duty=0:
  - cur_duty goes 4 → 8 → 12 at every 2nd period_end.
  - busy drops the cycle after reaching 12.
  - Config period=20, duty=10, step=4: cur_duty must not undershoot and ends at exactly 10.
- Back-to-back config, second cfg_valid held: cfg_ready low until the apply at period_end; second word transfers the cycle after cfg_ready rises. Config with duty=50, period=20 → cur_duty saturates at 20, pwm constantly high.
- Mid-operation cases:
  - Drop enable at cnt=5 → pwm=0 and cnt=0 next cycle, cur_duty retained.
  - Assert reset mid-ramp → all outputs return to their reset values asynchronously.
- With PWM_SOFT_STOP_EN, cur_duty=12, step=4, RAMP_DIV=1: drop enable → cur_duty goes 8, 4, 0 on successive period_ends, then IDLE with pwm=0 and busy=0.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Single-channel PWM with shadowed period/duty/step config and stepped duty slew.
// Optional macro PWM_SOFT_STOP_EN: on enable drop, ramp duty to zero before stopping.
module pwm_ramp_sequencer #(
   parameter int CNT_W    = 16,
   parameter int STEP_W   = 8,
   parameter int RAMP_DIV = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_duty,
   input  logic [STEP_W-1:0] cfg_step,
   output logic              pwm,
   output logic              period_end,
   output logic [CNT_W-1:0]  cur_duty,
   output logic              busy
);
   localparam int RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [RDW-1:0] RD_LAST = RDW'(RAMP_DIV - 1);

`ifdef PWM_SOFT_STOP_EN
   typedef enum logic [1:0] {IDLE, RUN, RAMP, STOPPING} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, RAMP} state_t;
`endif

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n, period_reg, per_n, target, tgt_n;
   logic [CNT_W-1:0]  cur_n, goal, stepped;
   logic [CNT_W-1:0]  sh_period, sh_duty;
   logic [STEP_W-1:0] step_reg, stp_n, sh_step;
   logic [RDW-1:0]    rdc, rdc_n;
   logic [CNT_W:0]    up_sum, dn_gap, step_x;
   logic              pending, pend_n, apply, drive, pwm_n, pe_n, busy_n;

   assign cfg_ready = !pending;

   always_comb begin
      per_n  = period_reg;
      tgt_n  = target;
      stp_n  = step_reg;
      pend_n = pending;

      // Shadow values land only at a period boundary (or immediately when stopped)
      apply = pending && ((state == IDLE) || period_end);
      if (apply) begin
         per_n  = (sh_period == '0) ? CNT_W'(1) : sh_period;
         tgt_n  = (sh_duty > per_n) ? per_n : sh_duty;
         stp_n  = sh_step;
         pend_n = 1'b0;
      end
      if (cfg_valid && !pending)
         pend_n = 1'b1;

      goal = tgt_n;
`ifdef PWM_SOFT_STOP_EN
      if (!enable)
         goal = '0;
`endif

      // One slew step toward goal, saturating so it never overshoots
      step_x = (CNT_W+1)'(stp_n);
      up_sum = {1'b0, cur_duty} + step_x;
      dn_gap = {1'b0, cur_duty} - {1'b0, goal};
      if (stp_n == '0)
         stepped = goal;
      else if (cur_duty < goal)
         stepped = (up_sum >= {1'b0, goal}) ? goal : up_sum[CNT_W-1:0];
      else
         stepped = (dn_gap <= step_x) ? goal : cur_duty - step_x[CNT_W-1:0];

      cur_n   = cur_duty;
      rdc_n   = rdc;
      cnt_n   = '0;
      state_n = state;

      if (state == IDLE) begin
         rdc_n = '0;
         if (enable)
            state_n = (tgt_n != cur_duty) ? RAMP : RUN;
      end else begin
         cnt_n = period_end ? '0 : cnt + 1'b1;
         if (period_end && (cur_duty != goal)) begin
            if ((stp_n == '0) || (rdc == RD_LAST)) begin
               rdc_n = '0;
               cur_n = stepped;
            end else begin
               rdc_n = rdc + 1'b1;
            end
         end
         state_n = (cur_n != goal) ? RAMP : RUN;
`ifdef PWM_SOFT_STOP_EN
         if (!enable) begin
            state_n = STOPPING;
            if (period_end && (cur_n == '0)) begin
               state_n = IDLE;
               cnt_n   = '0;
               rdc_n   = '0;
            end
         end
`else
         if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            rdc_n   = '0;
            cur_n   = cur_duty;
         end
`endif
      end

`ifdef PWM_SOFT_STOP_EN
      drive  = (state_n != IDLE);
      busy_n = (state_n == RAMP) || (state_n == STOPPING);
`else
      drive  = enable;
      busy_n = (state_n == RAMP);
`endif
      pwm_n = drive && (cnt < cur_duty);
      pe_n  = (state_n != IDLE) && (cnt_n == per_n - 1'b1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         period_reg <= CNT_W'(1);
         target     <= '0;
         step_reg   <= '0;
         cur_duty   <= '0;
         pending    <= 1'b0;
         rdc        <= '0;
         pwm        <= 1'b0;
         period_end <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         period_reg <= per_n;
         target     <= tgt_n;
         step_reg   <= stp_n;
         cur_duty   <= cur_n;
         pending    <= pend_n;
         rdc        <= rdc_n;
         pwm        <= pwm_n;
         period_end <= pe_n;
         busy       <= busy_n;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sh_period <= '0;
         sh_duty   <= '0;
         sh_step   <= '0;
      end else if (cfg_valid && !pending) begin
         sh_period <= cfg_period;
         sh_duty   <= cfg_duty;
         sh_step   <= cfg_step;
      end
   end
endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: cycle table plus multi-cycle ramp/handshake sequences.
module tb_pwm_ramp_sequencer;
   localparam int CNT_W    = 16;
   localparam int STEP_W   = 8;
   localparam int RAMP_DIV = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [CNT_W-1:0]  cfg_period = '0;
   logic [CNT_W-1:0]  cfg_duty = '0;
   logic [STEP_W-1:0] cfg_step = '0;
   logic              pwm, period_end, busy;
   logic [CNT_W-1:0]  cur_duty;

   int checks = 0;
   int errors = 0;
   int nc;
   int highs, pes;

   typedef struct {
      logic              en, vld;
      logic [CNT_W-1:0]  per, duty;
      logic [STEP_W-1:0] step;
      logic              pwm, pe;
      logic [CNT_W-1:0]  cur;
      logic              busy, rdy;
   } vec_t;
   vec_t tbl[$];

   pwm_ramp_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W), .RAMP_DIV(RAMP_DIV)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_step(cfg_step),
      .pwm(pwm), .period_end(period_end), .cur_duty(cur_duty), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic en, vld, input int per, duty, step,
                      input logic p, pe, input int cur, input logic b, r);
      vec_t v;
      v.en = en; v.vld = vld; v.per = CNT_W'(per); v.duty = CNT_W'(duty);
      v.step = STEP_W'(step); v.pwm = p; v.pe = pe; v.cur = CNT_W'(cur);
      v.busy = b; v.rdy = r;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
      cfg_period = '0; cfg_duty = '0; cfg_step = '0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic send(input int p, d, s);
      cfg_period = CNT_W'(p); cfg_duty = CNT_W'(d); cfg_step = STEP_W'(s);
      cfg_valid = 1'b1;
      @(negedge clock);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_pe(input string name, input int max, output int n);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!period_end && n < max);
      if (!period_end) begin
         checks++;
         errors++;
         $display("FAIL %s: period_end not seen within %0d cycles", name, max);
      end
   endtask

   initial begin
      // en vld per duty step | pwm pe cur busy rdy
      add(1, 0, 0, 0, 0,  0, 1, 0, 0, 1);
      add(1, 0, 0, 0, 0,  0, 1, 0, 0, 1);
      add(1, 1, 4, 2, 0,  0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0,  0, 0, 2, 0, 1);
      add(1, 0, 0, 0, 0,  1, 0, 2, 0, 1);
      add(1, 0, 0, 0, 0,  1, 0, 2, 0, 1);
      add(1, 0, 0, 0, 0,  0, 1, 2, 0, 1);
      add(1, 0, 0, 0, 0,  0, 0, 2, 0, 1);
      add(1, 0, 0, 0, 0,  1, 0, 2, 0, 1);
`ifndef PWM_SOFT_STOP_EN
      add(0, 0, 0, 0, 0,  0, 0, 2, 0, 1);
      add(0, 0, 0, 0, 0,  0, 0, 2, 0, 1);
      add(1, 0, 0, 0, 0,  1, 0, 2, 0, 1);
`endif

      // reset values
      @(negedge clock);
      chk("rst pwm", pwm, 0);
      chk("rst period_end", period_end, 0);
      chk("rst cur_duty", cur_duty, 0);
      chk("rst busy", busy, 0);
      chk("rst cfg_ready", cfg_ready, 1);
      @(negedge clock);
      reset = 1'b0;

      // cycle table: period 1 default, then period 4 duty 2 jump
      for (int i = 0; i < tbl.size(); i++) begin
         enable = tbl[i].en; cfg_valid = tbl[i].vld;
         cfg_period = tbl[i].per; cfg_duty = tbl[i].duty; cfg_step = tbl[i].step;
         @(negedge clock);
         chk($sformatf("v%0d pwm", i), pwm, tbl[i].pwm);
         chk($sformatf("v%0d period_end", i), period_end, tbl[i].pe);
         chk($sformatf("v%0d cur_duty", i), cur_duty, tbl[i].cur);
         chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
         chk($sformatf("v%0d cfg_ready", i), cfg_ready, tbl[i].rdy);
      end
      cfg_valid = 1'b0;

      // period 10, duty 3, jump: 3 high / 7 low after first period_end
      do_reset();
      send(10, 3, 0);
      @(negedge clock);
      enable = 1'b1;
      @(negedge clock);
      chk("p10 busy before jump", busy, 1);
      wait_pe("p10 first", 15, nc);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         chk($sformatf("p10 pwm k%0d", k), pwm, ((k % 10) >= 2) && ((k % 10) <= 4));
         chk($sformatf("p10 pe k%0d", k), period_end, (k % 10) == 0);
      end
      chk("p10 cur_duty", cur_duty, 3);
      chk("p10 busy", busy, 0);

      // ramp up 4/8/12 every 2nd period_end, then down to 10 without undershoot
      do_reset();
      send(20, 12, 4);
      enable = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         wait_pe("ramp up", 30, nc);
         @(negedge clock);
         chk($sformatf("ramp up cur k%0d", k), cur_duty, 4 * (k / 2));
         chk($sformatf("ramp up busy k%0d", k), busy, k < 6);
      end
      chk("ramp down ready", cfg_ready, 1);
      send(20, 10, 4);
      wait_pe("ramp down a", 30, nc);
      @(negedge clock);
      chk("ramp down cur a", cur_duty, 12);
      chk("ramp down busy a", busy, 1);
      wait_pe("ramp down b", 30, nc);
      @(negedge clock);
      chk("ramp down cur b", cur_duty, 10);
      chk("ramp down busy b", busy, 0);
      wait_pe("ramp down c", 30, nc);
      @(negedge clock);
      chk("ramp down cur c", cur_duty, 10);

      // back-to-back config with second word held; second clamps duty to period
      do_reset();
      send(6, 2, 0);
      enable = 1'b1;
      wait_pe("b2b start", 20, nc);
      @(negedge clock);
      chk("b2b cur first", cur_duty, 2);
      cfg_period = 16'd8; cfg_duty = 16'd4; cfg_step = '0; cfg_valid = 1'b1;
      @(negedge clock);
      chk("b2b ready after A", cfg_ready, 0);
      cfg_period = 16'd20; cfg_duty = 16'd50;
      wait_pe("b2b A apply", 12, nc);
      chk("b2b ready at pe", cfg_ready, 0);
      @(negedge clock);
      chk("b2b ready after apply", cfg_ready, 1);
      chk("b2b cur A", cur_duty, 4);
      @(negedge clock);
      chk("b2b ready after B", cfg_ready, 0);
      cfg_valid = 1'b0;
      wait_pe("b2b B apply", 12, nc);
      @(negedge clock);
      chk("b2b cur B clamped", cur_duty, 20);
      chk("b2b ready end", cfg_ready, 1);
      highs = 0; pes = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         highs += int'(pwm);
         pes += int'(period_end);
      end
      chk("b2b pwm full high", highs, 40);
      chk("b2b pe count", pes, 2);

`ifndef PWM_SOFT_STOP_EN
      // enable drop at cnt=5, then restart from cnt=0
      do_reset();
      send(10, 8, 0);
      enable = 1'b1;
      wait_pe("drop start", 15, nc);
      for (int k = 0; k < 6; k++) @(negedge clock);
      chk("drop pwm before", pwm, 1);
      enable = 1'b0;
      @(negedge clock);
      chk("drop pwm", pwm, 0);
      chk("drop pe", period_end, 0);
      chk("drop cur kept", cur_duty, 8);
      chk("drop busy", busy, 0);
      enable = 1'b1;
      wait_pe("drop restart", 15, nc);
      chk("drop restart period", nc, 10);
`endif

      // asynchronous reset in the middle of a ramp with a config pending
      do_reset();
      send(20, 12, 4);
      enable = 1'b1;
      wait_pe("areset a", 30, nc);
      wait_pe("areset b", 30, nc);
      @(negedge clock);
      send(20, 12, 4);
      chk("areset pre cur", cur_duty, 4);
      chk("areset pre busy", busy, 1);
      chk("areset pre ready", cfg_ready, 0);
      chk("areset pre pwm", pwm, 1);
      #2 reset = 1'b1;
      #1;
      chk("areset cur", cur_duty, 0);
      chk("areset busy", busy, 0);
      chk("areset ready", cfg_ready, 1);
      chk("areset pwm", pwm, 0);
      chk("areset pe", period_end, 0);
      @(negedge clock);
      reset = 1'b0;

`ifdef PWM_SOFT_STOP_EN
      // soft stop from 12 with step 4: 8, 4, 0 every 2nd period_end, then idle
      do_reset();
      send(20, 12, 0);
      enable = 1'b1;
      wait_pe("soft jump", 25, nc);
      @(negedge clock);
      chk("soft cur 12", cur_duty, 12);
      send(20, 12, 4);
      wait_pe("soft apply", 25, nc);
      @(negedge clock);
      enable = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         wait_pe("soft stop", 25, nc);
         @(negedge clock);
         chk($sformatf("soft cur k%0d", k), cur_duty, 12 - 4 * (k / 2));
         chk($sformatf("soft busy k%0d", k), busy, k < 6);
      end
      chk("soft pwm idle", pwm, 0);
      pes = 0; highs = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clock);
         highs += int'(pwm);
         pes += int'(period_end);
      end
      chk("soft idle pwm", highs, 0);
      chk("soft idle pe", pes, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
